// File: rtl/fp_pkg.sv
// Shared FP32 types and constants for the multiplier/adder datapaths.
// Rounding-mode encoding, magnitudes and the packed single layout.
package fp_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rmode_e;

  localparam int          EXP_BIAS   = 127;
  localparam logic [30:0] FP_INF_MAG = 31'h7F800000;
  localparam logic [30:0] FP_MAX_MAG = 31'h7F7FFFFF;
  localparam logic [31:0] QNAN       = 32'h7FC00000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  // Reserved encodings 5..7 behave as round-to-nearest-even.
  function automatic rmode_e rmode_norm(
    input logic [2:0] m
  );
    if (m > 3'd4) return RNE;
    return rmode_e'(m);
  endfunction

endpackage

// File: rtl/fp_mul_round_pipe_inc.sv
// Round-increment decision shared by the FP multiplier and adder paths.
// Pure combinational: sign, kept LSB, guard and sticky in, increment out.
module fp_round_inc
  import fp_pkg::*;
(
  input  logic       i_sign,
  input  logic       i_lsb,
  input  logic       i_g,
  input  logic       i_s,
  input  logic [2:0] i_rmode,
  output logic       o_inc
);

  always_comb begin
    o_inc = 1'b0;
    case (rmode_norm(i_rmode))
      RNE:     o_inc = i_g && (i_s || i_lsb);
      RTZ:     o_inc = 1'b0;
      RDN:     o_inc = i_sign && (i_g || i_s);
      RUP:     o_inc = !i_sign && (i_g || i_s);
      RMM:     o_inc = i_g;
      default: o_inc = i_g && (i_s || i_lsb);
    endcase
  end

endmodule

// File: rtl/fp_mul_round_pipe.sv
// FP32 multiplier back end: normalize, round, pack over a 2-stage pipe.
// Optional sticky flags when FP_MUL_STICKY_FLAGS_EN is defined.
module fp_mul_round_pipe
  import fp_pkg::*;
#(
  parameter int          EXP_W = 10,
  parameter logic [31:0] QNAN  = 32'h7FC00000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sign,
  input  logic signed [EXP_W-1:0] exp_sum,
  input  logic [47:0]             frc_Z_full,
  input  logic                    is_zero,
  input  logic                    is_inf,
  input  logic                    is_nan,
  input  logic [2:0]              r_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef FP_MUL_STICKY_FLAGS_EN
  input  logic                    flag_clr,
  output logic                    sticky_ovrf,
  output logic                    sticky_udrf,
`endif
  output logic [31:0]             fp_Z,
  output logic                    ovrf,
  output logic                    udrf
);

  localparam int EW = EXP_W + 1;
  localparam logic signed [EW-1:0] EMAX = EW'(255);
  localparam logic signed [EW-1:0] EMIN = EW'(0);

  logic w_s1_en;
  logic w_s2_en;

  logic                 w_norm;
  logic [23:0]          w_sig;
  logic                 w_g;
  logic                 w_s;
  logic signed [EW-1:0] w_e;

  logic                 r_s1_valid;
  logic                 r_s1_sign;
  logic [23:0]          r_s1_sig;
  logic                 r_s1_g;
  logic                 r_s1_s;
  logic signed [EW-1:0] r_s1_e;
  logic                 r_s1_nan;
  logic                 r_s1_inf;
  logic                 r_s1_zero;
  logic [2:0]           r_s1_rmode;

  logic                 w_inc;
  logic                 w_c23;
  logic                 w_carry;
  logic [22:0]          w_frac;
  logic signed [EW-1:0] w_e2;
  logic                 w_ovf_inf;
  fp32_t                w_pk;
  logic [31:0]          w_z;
  logic                 w_ovf;
  logic                 w_udf;

  logic                 r_out_valid;
  logic [31:0]          r_fp_z;
  logic                 r_ovrf;
  logic                 r_udrf;

  assign w_s2_en  = !r_out_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign in_ready = w_s1_en;

  assign w_norm = frc_Z_full[47];
  assign w_sig  = w_norm ? frc_Z_full[47:24]
                         : frc_Z_full[46:23];
  assign w_g    = w_norm ? frc_Z_full[23]
                         : frc_Z_full[22];
  assign w_s    = w_norm ? |frc_Z_full[22:0]
                         : |frc_Z_full[21:0];
  assign w_e    = {exp_sum[EXP_W-1], exp_sum}
                + {{EXP_W{1'b0}}, w_norm};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_s1_en && in_valid) begin
      r_s1_sign  <= sign;
      r_s1_sig   <= w_sig;
      r_s1_g     <= w_g;
      r_s1_s     <= w_s;
      r_s1_e     <= w_e;
      r_s1_nan   <= is_nan;
      r_s1_inf   <= is_inf;
      r_s1_zero  <= is_zero;
      r_s1_rmode <= r_mode;
    end
  end

  fp_round_inc u_inc (
    .i_sign  (r_s1_sign),
    .i_lsb   (r_s1_sig[0]),
    .i_g     (r_s1_g),
    .i_s     (r_s1_s),
    .i_rmode (r_s1_rmode),
    .o_inc   (w_inc)
  );

  // Carry out of the 24-bit significand needs the low 23 bits to wrap
  // and the leading bit set; the wrapped fraction is then already zero.
  assign {w_c23, w_frac} = {1'b0, r_s1_sig[22:0]} + 24'(w_inc);
  assign w_carry = w_c23 & r_s1_sig[23];
  assign w_e2    = r_s1_e + {{EXP_W{1'b0}}, w_carry};

  always_comb begin
    w_ovf_inf = 1'b1;
    case (rmode_norm(r_s1_rmode))
      RTZ:     w_ovf_inf = 1'b0;
      RDN:     w_ovf_inf = r_s1_sign;
      RUP:     w_ovf_inf = !r_s1_sign;
      default: w_ovf_inf = 1'b1;
    endcase
  end

  assign w_pk = '{
    sign: r_s1_sign,
    exp:  w_e2[7:0],
    frac: w_frac
  };

  always_comb begin
    w_z   = '0;
    w_ovf = 1'b0;
    w_udf = 1'b0;
    if (r_s1_nan) begin
      w_z = QNAN;
    end else if (r_s1_inf) begin
      w_z = {r_s1_sign, FP_INF_MAG};
    end else if (r_s1_zero) begin
      w_z = {r_s1_sign, 31'b0};
    end else if (w_e2 >= EMAX) begin
      w_ovf = 1'b1;
      w_z   = {r_s1_sign,
               w_ovf_inf ? FP_INF_MAG : FP_MAX_MAG};
    end else if (w_e2 <= EMIN) begin
      w_udf = 1'b1;
      w_z   = {r_s1_sign, 31'b0};
    end else begin
      w_z = w_pk;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_fp_z      <= '0;
      r_ovrf      <= 1'b0;
      r_udrf      <= 1'b0;
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
      r_fp_z      <= r_s1_valid ? w_z : 32'b0;
      r_ovrf      <= r_s1_valid && w_ovf;
      r_udrf      <= r_s1_valid && w_udf;
    end
  end

  assign out_valid = r_out_valid;
  assign fp_Z      = r_fp_z;
  assign ovrf      = r_ovrf;
  assign udrf      = r_udrf;

`ifdef FP_MUL_STICKY_FLAGS_EN
  logic w_xfer;
  logic r_st_ovrf;
  logic r_st_udrf;

  assign w_xfer = r_out_valid && out_ready;

  // A flagged transfer outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st_ovrf <= 1'b0;
      r_st_udrf <= 1'b0;
    end else begin
      if (w_xfer && r_ovrf) r_st_ovrf <= 1'b1;
      else if (flag_clr)    r_st_ovrf <= 1'b0;
      if (w_xfer && r_udrf) r_st_udrf <= 1'b1;
      else if (flag_clr)    r_st_udrf <= 1'b0;
    end
  end

  assign sticky_ovrf = r_st_ovrf;
  assign sticky_udrf = r_st_udrf;
`endif

endmodule

// File: tb/tb_fp_mul_round_pipe.sv
// Scoreboard bench for fp_mul_round_pipe: directed plan cases,
// backpressure, mid-flight reset, then randomized traffic.
module tb_fp_mul_round_pipe;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               sign;
  logic signed [9:0]  exp_sum;
  logic [47:0]        frc_Z_full;
  logic               is_zero;
  logic               is_inf;
  logic               is_nan;
  logic [2:0]         r_mode;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        fp_Z;
  logic               ovrf;
  logic               udrf;
`ifdef FP_MUL_STICKY_FLAGS_EN
  logic               flag_clr;
  logic               sticky_ovrf;
  logic               sticky_udrf;
`endif

  always #5 clk = ~clk;

  fp_mul_round_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sign       (sign),
    .exp_sum    (exp_sum),
    .frc_Z_full (frc_Z_full),
    .is_zero    (is_zero),
    .is_inf     (is_inf),
    .is_nan     (is_nan),
    .r_mode     (r_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef FP_MUL_STICKY_FLAGS_EN
    .flag_clr   (flag_clr),
    .sticky_ovrf(sticky_ovrf),
    .sticky_udrf(sticky_udrf),
`endif
    .fp_Z       (fp_Z),
    .ovrf       (ovrf),
    .udrf       (udrf)
  );

  typedef struct {
    logic [31:0] z;
    logic        o;
    logic        u;
  } exp_t;

  exp_t q[$];
  exp_t dir_exp;
  bit   dir_on = 0;
  bit   rnd_ready = 0;
  int   errs = 0;
  int   checks = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Reference: value-level rounding of the integer product.
  function automatic exp_t model(logic s, int es, logic [47:0] p,
                                 logic nan, logic inf, logic zero,
                                 logic [2:0] rm);
    exp_t r;
    longint unsigned qv, rem, half;
    int drop, e;
    bit up;
    r.z = 0; r.o = 0; r.u = 0;
    drop = p[47] ? 24 : 23;
    qv   = 64'(p) >> drop;
    rem  = 64'(p) & ((64'd1 << drop) - 64'd1);
    half = 64'd1 << (drop - 1);
    e    = es + (p[47] ? 1 : 0);
    case (rm)
      3'd1:    up = 0;
      3'd2:    up = s && (rem != 0);
      3'd3:    up = !s && (rem != 0);
      3'd4:    up = rem >= half;
      default: up = (rem > half) || (rem == half && qv[0]);
    endcase
    qv = qv + 64'(up);
    if (qv == (64'd1 << 24)) begin
      qv = qv >> 1;
      e  = e + 1;
    end
    if (nan) r.z = 32'h7FC00000;
    else if (inf) r.z = {s, 31'h7F800000};
    else if (zero) r.z = {s, 31'h0};
    else if (e >= 255) begin
      r.o = 1;
      case (rm)
        3'd1:    r.z = {s, 31'h7F7FFFFF};
        3'd2:    r.z = {s, s ? 31'h7F800000 : 31'h7F7FFFFF};
        3'd3:    r.z = {s, s ? 31'h7F7FFFFF : 31'h7F800000};
        default: r.z = {s, 31'h7F800000};
      endcase
    end else if (e <= 0) begin
      r.u = 1;
      r.z = {s, 31'h0};
    end else begin
      r.z = {s, 8'(e), qv[22:0]};
    end
    return r;
  endfunction

  // Transfers happen on the next posedge; sample both sides here.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        if (dir_on) q.push_back(dir_exp);
        else q.push_back(model(sign, int'(exp_sum), frc_Z_full,
                               is_nan, is_inf, is_zero, r_mode));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected output", fp_Z, 32'hxxxxxxxx);
        end else begin
          exp_t x;
          x = q.pop_front();
          chk("fp_Z", fp_Z, x.z);
          chk("ovrf", 32'(ovrf), 32'(x.o));
          chk("udrf", 32'(udrf), 32'(x.u));
        end
      end else if (!out_valid) begin
        chk("idle flags", 32'({ovrf, udrf}), 32'd0);
      end
    end
  end

  task automatic present(logic s, int es, logic [47:0] p,
                         logic nan, logic inf, logic zero,
                         logic [2:0] rm);
    sign = s; exp_sum = 10'(es); frc_Z_full = p;
    is_nan = nan; is_inf = inf; is_zero = zero; r_mode = rm;
    in_valid = 1;
  endtask

  task automatic send(logic s, int es, logic [47:0] p,
                      logic nan, logic inf, logic zero,
                      logic [2:0] rm);
    int  n;
    bit  acc;
    n = 0; acc = 0;
    present(s, es, p, nan, inf, zero, rm);
    while (!acc) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
      if (!acc && n > 50) begin
        chk("send timeout", 32'(n), 32'd0);
        break;
      end
    end
    in_valid = 0;
  endtask

  task automatic send_dir(logic s, int es, logic [47:0] p,
                          logic nan, logic inf, logic zero,
                          logic [2:0] rm, logic [31:0] z,
                          logic o, logic u);
    dir_exp.z = z; dir_exp.o = o; dir_exp.u = u;
    dir_on = 1;
    send(s, es, p, nan, inf, zero, rm);
    dir_on = 0;
  endtask

  task automatic drain();
    in_valid = 0; out_ready = 1; rnd_ready = 0;
    for (int n = 0; n < 30 && q.size() > 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic rnd_item(output logic s, output int es,
                          output logic [47:0] p, output logic nan,
                          output logic inf, output logic zero,
                          output logic [2:0] rm);
    logic [23:0] a, b;
    int k;
    a = {1'b1, 23'($urandom)};
    b = {1'b1, 23'($urandom)};
    p = 48'(a) * 48'(b);
    s = 1'($urandom);
    k = $urandom_range(0, 3);
    if (k == 0) es = $urandom_range(0, 12) - 10;
    else if (k == 1) es = $urandom_range(248, 258);
    else es = $urandom_range(0, 320) - 10;
    k = $urandom_range(0, 15);
    nan = (k == 0) || (k == 3);
    inf = (k == 1);
    zero = (k == 2) || (k == 3);
    rm = 3'($urandom_range(0, 7));
  endtask

  localparam logic [47:0] P15 = 48'h900000000000;
  localparam logic [47:0] PRC = 48'h7FFFFFC00000;

  logic        s_r, n_r, i_r, z_r;
  logic [47:0] p_r;
  logic [2:0]  m_r;
  int          e_r;
  logic [31:0] held;
  int          idx;
  bit          rdy;

  initial begin
    rst = 1; in_valid = 0; out_ready = 1;
    sign = 0; exp_sum = 0; frc_Z_full = 0;
    is_zero = 0; is_inf = 0; is_nan = 0; r_mode = 0;
`ifdef FP_MUL_STICKY_FLAGS_EN
    flag_clr = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset fp_Z", fp_Z, 32'd0);
    chk("reset flags", 32'({ovrf, udrf}), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    send_dir(0, 127, P15, 0, 0, 0, 3'd0, 32'h40100000, 0, 0);
    send_dir(0, 127, PRC, 0, 0, 0, 3'd0, 32'h40000000, 0, 0);
    send_dir(0, 127, PRC, 0, 0, 0, 3'd1, 32'h3FFFFFFF, 0, 0);
    send_dir(0, 300, P15, 0, 0, 0, 3'd1, 32'h7F7FFFFF, 1, 0);
    send_dir(0, 300, P15, 0, 0, 0, 3'd0, 32'h7F800000, 1, 0);
    send_dir(1, 300, P15, 0, 0, 0, 3'd3, 32'hFF7FFFFF, 1, 0);
    send_dir(1, -5, P15, 0, 0, 0, 3'd0, 32'h80000000, 0, 1);
    send_dir(0, 127, P15, 1, 0, 0, 3'd0, 32'h7FC00000, 0, 0);
    send_dir(1, 127, P15, 0, 1, 0, 3'd0, 32'hFF800000, 0, 0);
    send_dir(1, 127, P15, 0, 0, 1, 3'd2, 32'h80000000, 0, 0);
    drain();
`ifdef FP_MUL_STICKY_FLAGS_EN
    chk("sticky ovrf set", 32'(sticky_ovrf), 32'd1);
    chk("sticky udrf set", 32'(sticky_udrf), 32'd1);
`endif

    // Backpressure: out_ready low for the first 3 cycles.
    idx = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      rnd_item(s_r, e_r, p_r, n_r, i_r, z_r, m_r);
      present(s_r, e_r, p_r, n_r, i_r, z_r, m_r);
      out_ready = (c >= 3);
      @(negedge clk);
      rdy = in_ready;
      if (c == 2) begin
        chk("bp in_ready", 32'(in_ready), 32'd0);
        chk("bp out_valid", 32'(out_valid), 32'd1);
        held = fp_Z;
      end
      if (c == 3) chk("bp hold", fp_Z, held);
      @(posedge clk); #1;
      if (rdy) idx++;
    end
    chk("bp accepted", 32'(idx), 32'd4);
    drain();

    // Reset with both stages full.
    out_ready = 0;
    for (int c = 0; c < 2; c++) begin
      rnd_item(s_r, e_r, p_r, n_r, i_r, z_r, m_r);
      present(s_r, e_r, p_r, n_r, i_r, z_r, m_r);
      @(posedge clk); #1;
    end
    chk("full before rst", 32'({out_valid, in_ready}), 32'b10);
    rst = 1; in_valid = 0;
    q.delete();
    @(posedge clk); #1;
    rst = 0;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst fp_Z", fp_Z, 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
`ifdef FP_MUL_STICKY_FLAGS_EN
    chk("rst sticky", 32'({sticky_ovrf, sticky_udrf}), 32'd0);
`endif
    out_ready = 1;
    drain();

    rnd_ready = 1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
      rnd_item(s_r, e_r, p_r, n_r, i_r, z_r, m_r);
      send(s_r, e_r, p_r, n_r, i_r, z_r, m_r);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
